// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// The entry struct is the unit carried from the memory response into decode.
package fetch_pkg;

  localparam int unsigned INSTRUCTIONS_MEM_SIZE = 4096;
  localparam int          FETCH_FIFO_DEPTH      = 2;
  localparam logic [31:0] FETCH_FAULT_INSTR     = 32'h0;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;

  // An address faults when it is not word aligned or its word runs past the end of memory.
  function automatic logic fetch_addr_faults(input logic [31:0] addr, input logic [31:0] last_pc);
    return (addr[1:0] != 2'b00) || (addr > last_pc);
  endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry in-order buffer of fetched entries with push, pop, flush and occupancy.
// Entry 0 is always the head; a pop shifts entry 1 down.
module fetch_skid_fifo
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  fetch_entry_t push_entry_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o
);

  fetch_entry_t slot_q [FETCH_FIFO_DEPTH];
  fetch_entry_t slot_d [FETCH_FIFO_DEPTH];
  logic [1:0]   count_q, count_d;
  logic [1:0]   wr_idx;
  logic         pop_ok;

  assign pop_ok = pop_i && (count_q != 2'd0);
  assign wr_idx = count_q - {1'b0, pop_ok};

  always_comb begin
    slot_d  = slot_q;
    count_d = count_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      if (pop_ok) begin
        slot_d[0] = slot_q[1];
      end
      if (push_i && (wr_idx < 2'd2)) begin
        slot_d[wr_idx[0]] = push_entry_i;
      end
      count_d = count_q + {1'b0, push_i} - {1'b0, pop_ok};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FETCH_FIFO_DEPTH; i++) begin
        slot_q[i] <= '0;
      end
      count_q <= 2'd0;
    end else begin
      slot_q  <= slot_d;
      count_q <= count_d;
    end
  end

  // The issue rule upstream reserves space for every in-flight request.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push_i && !flush_i && (wr_idx == 2'd2)));

  assign head_o  = (count_q != 2'd0) ? slot_q[0] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Drives the synchronous-read instruction memory and hands {pc, instr, fault} to decode.
// Handshake: a transfer happens at a rising edge where out_valid && out_ready; out_* hold while stalled.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MEM_SIZE = INSTRUCTIONS_MEM_SIZE
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_fault,
  output logic        dbg_state
);

  localparam logic [31:0] LAST_PC = 32'(MEM_SIZE - 4);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         inflight_valid_q, inflight_valid_d;
  logic [31:0]  inflight_pc_q, inflight_pc_d;
  logic         inflight_fault_q, inflight_fault_d;

  logic [31:0]  issue_addr;
  logic         issue_fault;
  logic         issue;
  logic         pop;
  logic         push;
  logic [2:0]   occupancy;
  logic [1:0]   fifo_count;
  fetch_entry_t fifo_head;
  fetch_entry_t push_entry;

  assign issue_addr  = redirect_valid ? redirect_pc : fetch_pc_q;
  assign mem_addr    = rst ? RESET_PC : issue_addr;
  assign issue_fault = fetch_addr_faults(issue_addr, LAST_PC);

  assign out_valid = (fifo_count != 2'd0);
  assign pop       = out_valid && out_ready;

  // Counting this cycle's pop lets issue continue without a bubble when ready rises.
  assign occupancy = {1'b0, fifo_count} + {2'b0, inflight_valid_q} - {2'b0, pop};
  assign issue     = redirect_valid || ((state_q == RUN) && (occupancy < 3'd2));

  assign push       = inflight_valid_q && !redirect_valid;
  assign push_entry = '{pc:    inflight_pc_q,
                        instr: inflight_fault_q ? FETCH_FAULT_INSTR : mem_rdata,
                        fault: inflight_fault_q};

  always_comb begin
    state_d          = state_q;
    fetch_pc_d       = fetch_pc_q;
    inflight_valid_d = 1'b0;
    inflight_pc_d    = inflight_pc_q;
    inflight_fault_d = inflight_fault_q;
    if (issue) begin
      inflight_valid_d = 1'b1;
      inflight_pc_d    = issue_addr;
      inflight_fault_d = issue_fault;
      fetch_pc_d       = issue_addr + 32'd4;
      state_d          = issue_fault ? HALT : RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= RUN;
      fetch_pc_q       <= RESET_PC;
      inflight_valid_q <= 1'b0;
      inflight_pc_q    <= 32'h0;
      inflight_fault_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      fetch_pc_q       <= fetch_pc_d;
      inflight_valid_q <= inflight_valid_d;
      inflight_pc_q    <= inflight_pc_d;
      inflight_fault_q <= inflight_fault_d;
    end
  end

  fetch_skid_fifo u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .flush_i      (redirect_valid),
    .head_o       (fifo_head),
    .count_o      (fifo_count)
  );

  assign out_pc    = fifo_head.pc;
  assign out_instr = fifo_head.instr;
  assign out_fault = fifo_head.fault;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios then randomized ready/redirect/reset traffic,
// scored against a stream model (expected PC queue restarted on every redirect or reset).
module tb_fetch_sequencer;
  import fetch_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int unsigned MEM_SIZE = 256;
  localparam int unsigned N_WORDS  = MEM_SIZE / 4;
  localparam logic [31:0] LAST_PC  = 32'(MEM_SIZE - 4);

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_fault;
  logic        dbg_state;

  fetch_sequencer #(.RESET_PC(RESET_PC), .MEM_SIZE(MEM_SIZE)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_fault      (out_fault),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / memory model ----------------
  always #5 clk = ~clk;

  logic [31:0] mem [N_WORDS];

  always @(posedge clk) begin
    if (mem_addr < MEM_SIZE) mem_rdata <= mem[int'(mem_addr >> 2)];
    else                     mem_rdata <= $urandom;
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          since = 0;
  bit          first_pending = 1'b0;
  int          hs_total = 0;
  bit          prev_valid = 1'b0, prev_ready = 1'b0, prev_restart = 1'b1, prev_rst = 1'b0;
  logic [31:0] prev_pc = '0, prev_instr = '0;
  logic        prev_fault = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_fault(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc > LAST_PC);
  endfunction

  function automatic logic [31:0] exp_instr(input logic [31:0] pc);
    return exp_fault(pc) ? 32'h0 : mem[int'(pc >> 2)];
  endfunction

  function automatic logic [31:0] pick_target();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7)       return {24'h0, 6'($urandom_range(0, N_WORDS - 1)), 2'b00};
    else if (r == 7) return {24'h0, 6'($urandom_range(0, N_WORDS - 1)), 2'($urandom_range(1, 3))};
    else if (r == 8) return MEM_SIZE + 32'($urandom_range(0, 15)) * 4;
    else             return (($urandom_range(0, 1) == 0) ? (LAST_PC - 32'd8) : 32'hFFFF_FFFC);
  endfunction

  // One cycle: check outputs at the falling edge, advance the model, then move past the rising edge.
  task automatic tick();
    logic [31:0] pc;
    logic [31:0] diff;
    @(negedge clk);
    if (rst) begin
      check_eq("rst_mem_addr", mem_addr, RESET_PC);
      if (prev_rst) begin
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_pc", out_pc, 32'd0);
        check_eq("rst_out_instr", out_instr, 32'd0);
        check_eq("rst_out_fault", 32'(out_fault), 32'd0);
        check_eq("rst_state", 32'(dbg_state), 32'd0);
      end
      exp_q.delete();
      exp_q.push_back(RESET_PC);
      since = -1;
      first_pending = 1'b1;
    end else begin
      if (first_pending) begin
        since++;
        if (since == 1) check_eq("latency_gap", 32'(out_valid), 32'd0);
        else if (since == 2) begin
          check_eq("latency_first", 32'(out_valid), 32'd1);
          first_pending = 1'b0;
        end
      end
      if (prev_valid && !prev_ready && !prev_restart) begin
        check_eq("hold_valid", 32'(out_valid), 32'd1);
        check_eq("hold_pc", out_pc, prev_pc);
        check_eq("hold_instr", out_instr, prev_instr);
        check_eq("hold_fault", 32'(out_fault), 32'(prev_fault));
      end
      if (exp_q.size() == 0) begin
        check_eq("after_fault_valid", 32'(out_valid), 32'd0);
        check_eq("after_fault_halt", 32'(dbg_state), 32'd1);
      end else if (!redirect_valid) begin
        diff = mem_addr - exp_q[0];
        check_eq("addr_ahead", 32'((diff == 0) || (diff == 4) || (diff == 8)), 32'd1);
      end
      if (out_valid && out_ready) begin
        hs_total++;
        if (exp_q.size() != 0) begin
          pc = exp_q.pop_front();
          check_eq("out_pc", out_pc, pc);
          check_eq("out_instr", out_instr, exp_instr(pc));
          check_eq("out_fault", 32'(out_fault), 32'(exp_fault(pc)));
          if (!exp_fault(pc)) exp_q.push_back(pc + 32'd4);
        end
      end
      if (redirect_valid) begin
        check_eq("redirect_mem_addr", mem_addr, redirect_pc);
        exp_q.delete();
        exp_q.push_back(redirect_pc);
        since = 0;
        first_pending = 1'b1;
      end
    end
    prev_valid   = out_valid;
    prev_ready   = out_ready;
    prev_pc      = out_pc;
    prev_instr   = out_instr;
    prev_fault   = out_fault;
    prev_restart = rst || redirect_valid;
    prev_rst     = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] target, input logic ready);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    out_ready      = ready;
    tick();
    redirect_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          h0;
    logic [31:0] a0;
    for (int i = 0; i < int'(N_WORDS); i++) mem[i] = $urandom;
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset release with ready high: two-cycle latency then one word per cycle.
    repeat (3) tick();
    rst = 1'b0;
    h0 = hs_total;
    repeat (12) tick();
    check_eq("stream_rate", 32'(hs_total - h0), 32'd10);

    // Ready low for five cycles: issue stops, address freezes, no bubble on resume.
    out_ready = 1'b0;
    tick();
    tick();
    a0 = mem_addr;
    repeat (3) tick();
    check_eq("frozen_addr", mem_addr, a0);
    out_ready = 1'b1;
    h0 = hs_total;
    repeat (6) tick();
    check_eq("resume_rate", 32'(hs_total - h0), 32'd6);

    // Redirect while buffered work is pending.
    out_ready = 1'b0;
    repeat (3) tick();
    do_redirect(32'h40, 1'b0);
    out_ready = 1'b1;
    repeat (6) tick();

    // Misaligned target faults and halts; a later redirect resumes.
    do_redirect(32'h42, 1'b1);
    repeat (6) tick();
    do_redirect(32'h10, 1'b1);
    repeat (6) tick();

    // Run off the end of memory, then redirect with a handshake in the same cycle.
    do_redirect(MEM_SIZE - 16, 1'b1);
    repeat (10) tick();
    do_redirect(MEM_SIZE - 24, 1'b0);
    repeat (3) tick();
    h0 = hs_total;
    do_redirect(32'h20, 1'b1);
    check_eq("redirect_hs_taken", 32'(hs_total - h0), 32'd1);
    repeat (6) tick();

    // Reset with a full buffer.
    out_ready = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (8) tick();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      rst = ($urandom_range(0, 999) < 3);
      if (!rst && ($urandom_range(0, 99) < 4)) begin
        do_redirect(pick_target(), out_ready);
      end else begin
        tick();
      end
    end
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
